// File: rtl/doc_uart_sender.sv
// Streams the whole text document out of the second RAM read port as 8N1 UART bytes,
// with a line feed after every row. Pulses done at the end so the editor can clear the document.
// One registered-tx cycle of lag; each frame takes 10*DIV+1 cycles; send is edge-triggered and ignored while busy.
module doc_uart_sender #(
   parameter int CLK_HZ    = 25000000,
   parameter int BAUD      = 115200,
   parameter int DOC_DEPTH = 512,
   parameter int ROW_LEN   = 32,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [7:0]        rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              read_enable,
   output logic              done,
   output logic              busy,
   output logic              tx
);

   localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DOC_DEPTH - 1);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] FETCH    = 4'd1;
   localparam logic [3:0] START    = 4'd2;
   localparam logic [3:0] DATA     = 4'd3;
   localparam logic [3:0] STOP     = 4'd4;
   localparam logic [3:0] LF_START = 4'd5;
   localparam logic [3:0] LF_DATA  = 4'd6;
   localparam logic [3:0] LF_STOP  = 4'd7;
   localparam logic [3:0] DONE     = 4'd8;

   logic [3:0]       state;
   logic             send_q;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [COL_W-1:0] column;
   logic [7:0]       shift;
   logic             lf_gap;   // spacer cycle before a line feed, playing the role FETCH plays for characters
   logic             baud_tick;

   assign baud_tick = (baud_cnt == CNT_LAST);

   // busy covers the accepted request through the done cycle itself
   assign busy = (state != IDLE) | done;

   // Main sequencer: request edge detect, document walk, frame bit timing
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         send_q      <= 1'b0;
         baud_cnt    <= '0;
         bit_idx     <= 3'd0;
         column      <= '0;
         shift       <= 8'hFF;
         lf_gap      <= 1'b0;
         rd_addr     <= '0;
         read_enable <= 1'b0;
         done        <= 1'b0;
      end else begin
         send_q <= send;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (send & ~send_q) begin
                  rd_addr     <= '0;
                  column      <= '0;
                  read_enable <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               // NUL cells are blank on screen, so they go out as spaces
               shift    <= (rd_data == 8'h00) ? 8'h20 : rd_data;
               baud_cnt <= '0;
               bit_idx  <= 3'd0;
               state    <= START;
            end
            START: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            LF_START: begin
               if (lf_gap) begin
                  lf_gap <= 1'b0;
               end else if (baud_tick) begin
                  baud_cnt <= '0;
                  state    <= LF_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA, LF_DATA: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= (state == DATA) ? STOP : LF_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  if (column == COL_LAST) begin
                     column <= '0;
                     shift  <= 8'h0A;
                     lf_gap <= 1'b1;
                     state  <= LF_START;
                  end else if (rd_addr == ADDR_LAST) begin
                     state <= DONE;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     column  <= column + 1'b1;
                     state   <= FETCH;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            LF_STOP: begin
               if (baud_tick) begin
                  baud_cnt <= '0;
                  if (rd_addr == ADDR_LAST) begin
                     state <= DONE;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     state   <= FETCH;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DONE: begin
               done        <= 1'b1;
               read_enable <= 1'b0;
               rd_addr     <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered TX line driven from the current state, idle high
   always_ff @(posedge clk) begin
      if (rst) begin
         tx <= 1'b1;
      end else begin
         case (state)
            START:         tx <= 1'b0;
            LF_START:      tx <= lf_gap;
            DATA, LF_DATA: tx <= shift[bit_idx];
            default:       tx <= 1'b1;
         endcase
      end
   end

endmodule
